// File: rtl/sram_debug_bridge.sv
// sram_debug_bridge: UART byte-stream initiator for the SRAM controller request bus.
//   rx_dat/rx_stb/rx_err   : received bytes and framing-error strobe
//   tx_dat/tx_stb/tx_busy  : transmit byte interface (read data, ping and ACK/NAK replies)
//   sram_*                 : level request, held stable until sram_ready
//   cpu_hold               : high from an accepted W/R command until its last tx byte is out
//   busy                   : FSM not idle
// Frame: CMD A2 A1 A0 LEN [data x LEN]; LEN=0 means 256 transfers.
module sram_debug_bridge #(
    parameter int ADDR_W         = 18,
    parameter int TIMEOUT_CYCLES = 1333333
) (
    input  logic              CLK0,
    input  logic              reset_n,
    input  logic [7:0]        rx_dat,
    input  logic              rx_stb,
    input  logic              rx_err,
    output logic [7:0]        tx_dat,
    output logic              tx_stb,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] sram_address,
    output logic [15:0]       sram_data_write,
    input  logic [15:0]       sram_data_read,
    output logic              sram_read,
    output logic              sram_write,
    input  logic              sram_ready,
    output logic              cpu_hold,
    output logic              busy
);
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;
    localparam logic [7:0] PONG = 8'h21;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR2, S_ADDR1, S_ADDR0, S_LEN, S_WDATA, S_WREQ,
        S_RREQ, S_TXSEND, S_TXWAIT, S_REPLY
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        data_q, data_d, reply_q, reply_d, skid_q, skid_d;
    logic              skid_v_q, skid_v_d, ovr_q, ovr_d, hold_q, hold_d;
    logic              wr_q, wr_d, rep_q, rep_d, txl_q;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              rx_ok, counting, expired, unused_hi;

    assign unused_hi = ^sram_data_read[15:8];
    // rx_err takes priority over a simultaneous byte
    assign rx_ok    = rx_stb && !rx_err;
    assign counting = state_q inside {S_ADDR2, S_ADDR1, S_ADDR0, S_LEN, S_WDATA};
    assign expired  = counting && !rx_stb && tmo_q == '0;
    // txl_q blocks a strobe in the cycle right after the previous one
    assign tx_stb          = (state_q == S_TXSEND || state_q == S_REPLY) && !tx_busy && !txl_q;
    assign tx_dat          = tx_stb ? (state_q == S_TXSEND ? data_q : reply_q) : 8'h00;
    assign sram_write      = state_q == S_WREQ;
    assign sram_read       = state_q == S_RREQ;
    assign sram_address    = addr_q;
    assign sram_data_write = {8'h00, data_q};
    assign cpu_hold        = hold_q;
    assign busy            = state_q != S_IDLE;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        reply_d  = reply_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        ovr_d    = ovr_q;
        hold_d   = hold_q;
        wr_d     = wr_q;
        tmo_d    = rx_stb ? TW'(TIMEOUT_CYCLES - 1) : (counting && tmo_q != '0) ? tmo_q - TW'(1) : tmo_q;
        case (state_q)
            S_IDLE: if (rx_ok) begin
                if (rx_dat == 8'h57 || rx_dat == 8'h52) begin
                    wr_d    = rx_dat == 8'h57;
                    hold_d  = 1'b1;
                    ovr_d   = 1'b0;
                    state_d = S_ADDR2;
                end else begin
                    reply_d = rx_dat == 8'h3F ? PONG : NAK;
                    state_d = S_REPLY;
                end
            end
            S_ADDR2: if (rx_ok) begin
                // any A2 bit above the address width makes the frame invalid
                if (({rx_dat, 16'h0000} >> ADDR_W) != 24'h0) begin
                    reply_d = NAK;
                    state_d = S_REPLY;
                end else begin
                    addr_d  = ADDR_W'(rx_dat);
                    state_d = S_ADDR1;
                end
            end
            S_ADDR1: if (rx_ok) begin
                addr_d  = ADDR_W'({addr_q, rx_dat});
                state_d = S_ADDR0;
            end
            S_ADDR0: if (rx_ok) begin
                addr_d  = ADDR_W'({addr_q, rx_dat});
                state_d = S_LEN;
            end
            S_LEN: if (rx_ok) begin
                cnt_d   = {rx_dat == 8'h00, rx_dat};
                state_d = wr_q ? S_WDATA : S_RREQ;
            end
            S_WDATA: if (skid_v_q) begin
                // drain the skid entry; a byte arriving now takes its place
                data_d   = skid_q;
                skid_v_d = rx_ok;
                skid_d   = rx_dat;
                state_d  = S_WREQ;
            end else if (rx_ok) begin
                data_d  = rx_dat;
                state_d = S_WREQ;
            end
            S_WREQ: begin
                ovr_d = ovr_q | (rx_ok & skid_v_q);
                if (rx_ok && !skid_v_q) begin
                    skid_v_d = 1'b1;
                    skid_d   = rx_dat;
                end
                if (sram_ready) begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        reply_d = ovr_d ? NAK : ACK;
                        state_d = S_REPLY;
                    end else begin
                        state_d = S_WDATA;
                    end
                end
            end
            S_RREQ: if (sram_ready) begin
                data_d  = sram_data_read[7:0];
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_q - 9'd1;
                state_d = S_TXSEND;
            end
            S_TXSEND: if (tx_stb) state_d = S_TXWAIT;
            S_TXWAIT: if (!txl_q && !tx_busy) state_d = cnt_q == 9'd0 ? S_IDLE : S_RREQ;
            S_REPLY:  if (tx_stb) state_d = S_TXWAIT;
            default:  state_d = S_IDLE;
        endcase
        if (expired) state_d = S_IDLE;
        // once a reply is underway further errors are ignored
        if (rx_err && state_q != S_IDLE && !rep_q) begin
            reply_d = NAK;
            state_d = S_REPLY;
        end
        if (state_d == S_REPLY) cnt_d = 9'd0;
        if (state_d != S_WDATA && state_d != S_WREQ) skid_v_d = 1'b0;
        if (state_d == S_IDLE) hold_d = 1'b0;
        rep_d = state_d == S_IDLE ? 1'b0 : state_d == S_REPLY ? 1'b1 : rep_q;
    end

    always_ff @(posedge CLK0) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            reply_q  <= '0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            ovr_q    <= 1'b0;
            hold_q   <= 1'b0;
            wr_q     <= 1'b0;
            rep_q    <= 1'b0;
            txl_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            reply_q  <= reply_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            ovr_q    <= ovr_d;
            hold_q   <= hold_d;
            wr_q     <= wr_d;
            rep_q    <= rep_d;
            txl_q    <= tx_stb;
            tmo_q    <= tmo_d;
        end
    end
endmodule

// File: tb/tb_sram_debug_bridge.sv
// tb_sram_debug_bridge: randomized self-checking bench for sram_debug_bridge
module tb_sram_debug_bridge;
    localparam int AW  = 18;
    localparam int TMO = 300;

    logic           CLK0 = 1'b0;
    logic           reset_n = 1'b0;
    logic [7:0]     rx_dat = 8'h00;
    logic           rx_stb = 1'b0;
    logic           rx_err = 1'b0;
    logic [7:0]     tx_dat;
    logic           tx_stb;
    logic           tx_busy = 1'b0;
    logic [AW-1:0]  sram_address;
    logic [15:0]    sram_data_write;
    logic [15:0]    sram_data_read = 16'h0000;
    logic           sram_read, sram_write;
    logic           sram_ready = 1'b0;
    logic           cpu_hold, busy;

    int errors = 0, checks = 0;
    logic [7:0]      mem [0:(1<<AW)-1];
    logic [7:0]      txq[$];
    logic [AW+15:0]  wlog[$];
    logic [AW-1:0]   rlog[$];
    int viol = 0, stab_err = 0, gap_err = 0;
    bit hold_seen = 0, stall = 0;
    int dmax = 0;

    sram_debug_bridge #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK0(CLK0), .reset_n(reset_n), .rx_dat(rx_dat), .rx_stb(rx_stb), .rx_err(rx_err),
        .tx_dat(tx_dat), .tx_stb(tx_stb), .tx_busy(tx_busy),
        .sram_address(sram_address), .sram_data_write(sram_data_write),
        .sram_data_read(sram_data_read), .sram_read(sram_read), .sram_write(sram_write),
        .sram_ready(sram_ready), .cpu_hold(cpu_hold), .busy(busy)
    );

    always #5 CLK0 = ~CLK0;

    // transmitter: records bytes, raises busy the cycle after a strobe
    bit txl = 0, pend = 0;
    int bcnt = 0;
    always @(negedge CLK0) begin
        if (cpu_hold) hold_seen = 1;
        if (tx_stb) begin
            if (tx_busy || txl) viol++;
            txq.push_back(tx_dat);
        end
        if (pend) begin
            tx_busy = 1'b1;
            bcnt = 4 + $urandom_range(0, 3);
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) tx_busy = 1'b0;
        end
        pend = tx_stb;
        txl = tx_stb;
    end

    // SRAM controller: random ready delay, stability and gap checks
    bit act = 0, w0 = 0;
    int wcnt = 0;
    logic [AW-1:0] a0;
    logic [15:0] d0;
    always @(negedge CLK0) begin
        if (sram_ready) begin
            sram_ready = 1'b0;
            if (sram_read || sram_write) gap_err++;
        end else if (sram_read || sram_write) begin
            if (!act) begin
                act = 1; wcnt = $urandom_range(0, dmax);
                a0 = sram_address; d0 = sram_data_write; w0 = sram_write;
            end else if (sram_address !== a0 || sram_write !== w0 || (w0 && sram_data_write !== d0)) stab_err++;
            if (!stall) begin
                if (wcnt == 0) begin
                    sram_ready = 1'b1;
                    act = 0;
                    if (w0) begin
                        mem[a0] = d0[7:0];
                        wlog.push_back({a0, d0});
                    end else begin
                        sram_data_read = {8'($urandom), mem[a0]};
                        rlog.push_back(a0);
                    end
                end else wcnt--;
            end
        end else act = 0;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [63:0] pk(logic [7:0] q[$]);
        logic [63:0] r = '0;
        foreach (q[i]) r = {r[55:0], q[i]};
        return r;
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge CLK0);
    endtask

    task automatic send(logic [7:0] b, int gap);
        rx_dat = b; rx_stb = 1'b1;
        @(negedge CLK0);
        rx_stb = 1'b0;
        tick(gap);
    endtask

    task automatic clear();
        txq.delete(); wlog.delete(); rlog.delete(); hold_seen = 0;
    endtask

    task automatic wait_idle(string nm);
        int n = 0;
        while ((busy || tx_busy) && n < 5000) begin
            @(negedge CLK0);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s idle: busy still %b after %0d cycles, required 0", nm, busy, n);
        end
        tick(3);
    endtask

    task automatic do_write(string nm, logic [AW-1:0] a, logic [7:0] d[$], int gap, int dm);
        int n = d.size();
        logic [AW+15:0] e;
        clear();
        dmax = dm;
        send(8'h57, 1); send({6'b0, a[17:16]}, 1); send(a[15:8], 1); send(a[7:0], 1); send(n[7:0], 1);
        foreach (d[i]) send(d[i], gap);
        wait_idle(nm);
        checks++;
        if (wlog.size() != n) begin
            errors++;
            $display("FAIL %s count: got %0d writes, required %0d", nm, wlog.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            e = {AW'((int'(a) + i) % (1 << AW)), 8'h00, d[i]};
            checks++;
            if (i >= wlog.size() || wlog[i] !== e) begin
                errors++;
                $display("FAIL %s write[%0d]: got %h, required %h", nm, i, i < wlog.size() ? wlog[i] : '0, e);
            end
        end
        checks++;
        if (txq.size() != 1 || txq[0] !== 8'h06) begin
            errors++;
            $display("FAIL %s ack: got %0d bytes %h, required 1 byte 06", nm, txq.size(), pk(txq));
        end
        checks++;
        if (cpu_hold !== 1'b0 || !hold_seen) begin
            errors++;
            $display("FAIL %s hold: got cpu_hold=%b seen=%b, required 0 and seen 1", nm, cpu_hold, hold_seen);
        end
    endtask

    task automatic do_read(string nm, logic [AW-1:0] a, logic [7:0] e[$], int dm);
        int n = e.size();
        clear();
        dmax = dm;
        send(8'h52, 0); send({6'b0, a[17:16]}, 0); send(a[15:8], 0); send(a[7:0], 0); send(n[7:0], 0);
        wait_idle(nm);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (i >= rlog.size() || rlog[i] !== AW'((int'(a) + i) % (1 << AW))) begin
                errors++;
                $display("FAIL %s raddr[%0d]: got %h, required %h", nm, i, i < rlog.size() ? rlog[i] : '0,
                         AW'((int'(a) + i) % (1 << AW)));
            end
        end
        checks++;
        if (txq.size() != n || pk(txq) !== pk(e)) begin
            errors++;
            $display("FAIL %s rdata: got %0d bytes %h, required %0d bytes %h", nm, txq.size(), pk(txq), n, pk(e));
        end
    endtask

    task automatic expect_nak(string nm, int nwr);
        checks++;
        if (txq.size() != 1 || txq[0] !== 8'h15 || wlog.size() != nwr || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL %s: got tx %0d bytes %h writes %0d hold %b, required tx 15 writes %0d hold 0",
                     nm, txq.size(), pk(txq), wlog.size(), cpu_hold, nwr);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        checks++;
        if ({tx_dat, tx_stb, sram_address, sram_data_write, sram_read, sram_write, cpu_hold, busy} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got tx=%h/%b a=%h d=%h r=%b w=%b hold=%b busy=%b, required all 0",
                     tx_dat, tx_stb, sram_address, sram_data_write, sram_read, sram_write, cpu_hold, busy);
        end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_ping();
        clear();
        send(8'h3F, 0);
        wait_idle("ping");
        checks++;
        if (txq.size() != 1 || txq[0] !== 8'h21) begin
            errors++;
            $display("FAIL ping reply: got %0d bytes %h, required 1 byte 21", txq.size(), pk(txq));
        end
        checks++;
        if (hold_seen) begin
            errors++;
            $display("FAIL ping hold: got cpu_hold seen=1, required 0");
        end
    endtask

    task automatic test_write();
        logic [7:0] q[$];
        q = {8'hAA, 8'hBB, 8'hCC};
        for (int dm = 0; dm <= 5; dm++) do_write("write3", 18'h12345, q, dm + 6, dm);
        for (int t = 0; t < 3; t++) begin
            q.delete();
            for (int i = 0; i < $urandom_range(1, 6); i++) q.push_back(8'($urandom));
            do_write("write_rand", t == 0 ? 18'h3FFFE : AW'($urandom), q, 7, 1);
        end
        q.delete();
        for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
        do_write("write_len0", AW'($urandom), q, 4, 1);
    endtask

    task automatic test_read_wrap();
        logic [7:0] e[$];
        mem[18'h3FFFF] = 8'h11;
        mem[18'h00000] = 8'h22;
        e = {8'h11, 8'h22};
        do_read("read_wrap", 18'h3FFFF, e, 3);
        for (int t = 0; t < 2; t++) begin
            logic [AW-1:0] a = AW'($urandom);
            e.delete();
            for (int i = 0; i < $urandom_range(1, 4); i++) e.push_back(mem[AW'((int'(a) + i) % (1 << AW))]);
            do_read("read_rand", a, e, 2);
        end
    endtask

    task automatic test_errors();
        clear();
        send(8'h99, 0);
        wait_idle("bad_cmd");
        expect_nak("bad_cmd", 0);
        clear();
        send(8'h57, 2); send(8'h04, 2);
        wait_idle("bad_a2");
        expect_nak("bad_a2", 0);
        clear();
        dmax = 0;
        send(8'h57, 2); send(8'h00, 2); send(8'h00, 2); send(8'h10, 2); send(8'h04, 2); send(8'hAA, 8);
        rx_err = 1'b1;
        tick(1);
        rx_err = 1'b0;
        send(8'hBB, 0); send(8'hCC, 0);
        wait_idle("err_wdata");
        expect_nak("err_wdata", 1);
        clear();
        send(8'h57, 2); send(8'h00, 2); send(8'h00, 2); send(8'h20, 2); send(8'h02, 2);
        rx_err = 1'b1;
        send(8'hDD, 0);
        rx_err = 1'b0;
        wait_idle("err_with_byte");
        expect_nak("err_with_byte", 0);
        clear();
        rx_err = 1'b1;
        tick(1);
        rx_err = 1'b0;
        tick(4);
        checks++;
        if (busy !== 1'b0 || txq.size() != 0) begin
            errors++;
            $display("FAIL err_idle: got busy=%b tx bytes=%0d, required 0 and 0", busy, txq.size());
        end
    endtask

    task automatic test_overrun();
        clear();
        dmax = 0;
        stall = 1;
        send(8'h57, 2); send(8'h00, 2); send(8'h01, 2); send(8'h00, 2); send(8'h03, 2);
        send(8'hAA, 3); send(8'hBB, 3); send(8'hCC, 3);
        tick(5);
        stall = 0;
        tick(10);
        send(8'hDD, 0);
        wait_idle("overrun");
        expect_nak("overrun", 3);
        checks++;
        if (wlog.size() != 3 || wlog[0] !== {18'h00100, 16'h00AA} || wlog[1] !== {18'h00101, 16'h00BB}
            || wlog[2] !== {18'h00102, 16'h00DD}) begin
            errors++;
            $display("FAIL overrun data: got %0d writes first %h, required AA@100 BB@101 DD@102",
                     wlog.size(), wlog.size() > 0 ? wlog[0] : '0);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        clear();
        send(8'h57, 0); send(8'h00, 0); send(8'h00, 0);
        while (busy && n < 2000) begin
            @(negedge CLK0);
            n++;
        end
        checks++;
        if (n < TMO - 2 || n > TMO + 2) begin
            errors++;
            $display("FAIL timeout cycles: got %0d, required %0d +/- 2", n, TMO);
        end
        tick(10);
        checks++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0 || txq.size() != 0) begin
            errors++;
            $display("FAIL timeout state: got busy=%b hold=%b tx=%0d, required 0 0 0", busy, cpu_hold, txq.size());
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear();
        stall = 1;
        send(8'h52, 1); send(8'h00, 1); send(8'h00, 1); send(8'h05, 1); send(8'h01, 1);
        while (!sram_read && n < 50) begin
            @(negedge CLK0);
            n++;
        end
        checks++;
        if (!sram_read) begin
            errors++;
            $display("FAIL reset_mid request: got sram_read=0, required 1");
        end
        reset_n = 1'b0;
        tick(1);
        checks++;
        if ({tx_dat, tx_stb, sram_address, sram_data_write, sram_read, sram_write, cpu_hold, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: got r=%b w=%b hold=%b busy=%b a=%h, required all 0",
                     sram_read, sram_write, cpu_hold, busy, sram_address);
        end
        tick(2);
        reset_n = 1'b1;
        stall = 0;
        tick(12);
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        for (int t = 0; t < 3; t++) begin
            int dm = $urandom_range(0, 3);
            logic [AW-1:0] a = AW'($urandom);
            q.delete();
            for (int i = 0; i < $urandom_range(1, 8); i++) q.push_back(8'($urandom));
            do_write("b2b_write", a, q, dm + 2, dm);
            do_read("b2b_read", a, q, dm);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        test_reset();
        test_ping();
        test_write();
        test_read_wrap();
        test_errors();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_ping();
        checks++;
        if (viol != 0 || stab_err != 0 || gap_err != 0) begin
            errors++;
            $display("FAIL bus rules: got tx_viol=%0d unstable=%0d no_gap=%0d, required 0 0 0", viol, stab_err, gap_err);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_debug_bridge.md
Name: sram_debug_bridge

Overview:
- Serial-driven SRAM bus initiator. Takes a byte stream from a UART receiver (acia_rx-style rx_dat/rx_stb) and issues reads/writes on the sram controller request interface (address/data_write/data_read/read/write/ready).
- Read data and status bytes go back through a UART transmitter byte interface.
- Used for loading and inspecting SRAM contents; cpu_hold lets the top level stall or reset the 65xx SoC while a command is active.

Parameters:
- ADDR_W, 18, SRAM word address width.
- TIMEOUT_CYCLES, 1333333, inter-byte timeout in CLK0 cycles; abort a partial command when it expires.

Ports:
- CLK0  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- rx_dat  in  8  received byte
- rx_stb  in  1  one-cycle strobe; rx_dat valid
- rx_err  in  1  one-cycle framing-error strobe
- tx_dat  out  8  byte to transmit
- tx_stb  out  1  one-cycle transmit strobe
- tx_busy  in  1  transmitter busy; rises the cycle after tx_stb
- sram_address  out  ADDR_W  request address
- sram_data_write  out  16  write data, {8'h00, byte}
- sram_data_read  in  16  read data; [7:0] used
- sram_read  out  1  read request, level
- sram_write  out  1  write request, level
- sram_ready  in  1  request complete; data_read valid in the same cycle
- cpu_hold  out  1  high while a command is in progress
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, skid buffer empty, overrun flag clear. Reset asserted mid-request drops sram_read/sram_write at the next edge without waiting for sram_ready.
- Frame format: CMD, A2, A1, A0, LEN, then LEN data bytes for a write.
  - Address = {A2[1:0], A1, A0}. A2[7:2] must be 0; otherwise send NAK.
  - LEN = 0 means 256 transfers.
- Commands:
  - 0x57 'W': write.
  - 0x52 'R': read.
  - 0x3F '?': ping; reply 0x21, no address phase.
  - Any other CMD: reply NAK 0x15, return to IDLE.
- State sequence: IDLE -> ADDR2 -> ADDR1 -> ADDR0 -> LEN -> (WDATA <-> WREQ) or (RREQ -> TXSEND -> TXWAIT) -> REPLY -> TXWAIT -> IDLE.
- cpu_hold: rises on acceptance of a valid W or R CMD byte. Falls when the final reply or data byte has finished transmitting (TXWAIT exit with tx_busy low).
- Write path:
  - WDATA waits for a byte from rx or the skid buffer.
  - WREQ holds sram_write=1, sram_address and sram_data_write stable until a cycle with sram_ready=1.
  - The request drops on the next edge; minimum one cycle low between requests.
  - Address increments by 1 per transfer and wraps 2^ADDR_W-1 -> 0.
  - After the last transfer, reply ACK 0x06, or NAK 0x15 if the overrun flag is set.
- Read path:
  - RREQ holds sram_read=1 until sram_ready. Latch sram_data_read[7:0] in the ready cycle.
  - TXSEND pulses tx_stb when tx_busy=0.
  - TXWAIT waits one cycle, then waits for tx_busy=0.
  - Repeat LEN times; no trailing ACK.
- TX rule: tx_stb is never asserted while tx_busy=1 or in the cycle directly after a previous tx_stb.
- Skid buffer: one entry.
  - rx_stb while in WREQ fills it.
  - rx_stb while it is full sets the sticky overrun flag; the byte is dropped.
  - Bytes arriving during the read or reply phases are discarded.
- rx_err in any non-IDLE state: abort any pending SRAM request (request drops next edge), reply NAK. In IDLE, ignore it.
- Timeout counter: reloads on every rx_stb, counts only in ADDR*/LEN/WDATA. At expiry, go silently to IDLE with cpu_hold=0.
- Simultaneous events:
  - rx_stb and sram_ready in the same cycle: complete the request and capture the byte into the skid buffer; no loss.
  - rx_err and rx_stb in the same cycle: rx_err wins.

Test Plan:
- Ping: rx 0x3F -> tx 0x21 exactly once; cpu_hold stays 0; busy returns 0.
- Write 3 bytes: rx 57 01 23 45 03 AA BB CC -> three sram_write handshakes at 0x12345/46/47 with data 0x00AA/0x00BB/0x00CC, then tx 0x06; cpu_hold low after the ACK finishes. Repeat with sram_ready delayed 0..5 cycles.
- Read with wrap: preload 0x3FFFF=0x11 and 0x00000=0x22; rx 52 03 FF FF 02 -> reads at 0x3FFFF then 0x00000; tx 0x11, 0x22. tx_stb never asserted during tx_busy.
- Errors: CMD 0x99 -> tx 0x15. A2=0x04 -> tx 0x15. rx_err during WDATA -> 0x15, no further SRAM writes.
- Overrun: hold sram_ready low while three data bytes arrive -> first written, second buffered, third dropped; final reply 0x15.
- Timeout and reset: stop after A1 -> after TIMEOUT_CYCLES, busy=0 with no tx. Assert reset_n=0 while sram_read=1 -> sram_read=0 next edge, all outputs 0.
